// File: rtl/md5_pkg.sv
// Shared definitions for the MD5 cracker front end: character range,
// default guess length and the candidate generator state encoding.
package md5_pkg;

    localparam logic [7:0] CHAR_MIN        = 8'h61;
    localparam logic [7:0] CHAR_MAX        = 8'h7a;
    localparam int         DEFAULT_MAX_LEN = 5;
    localparam int         GUESS_W         = 128;
    localparam int         LEN_W           = 5;
    localparam int         COUNT_W         = 32;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HALTED,
        DONE
    } pwgen_state_t;

    function automatic logic is_guess_char(input logic [7:0] c);
        return (c >= CHAR_MIN) && (c <= CHAR_MAX);
    endfunction

endpackage

// File: rtl/password_generator_if.sv
// Candidate stream from the password generator into the MD5 hash/compare stage.
interface password_generator_if;
    import md5_pkg::*;

    logic               guess_valid;
    logic               guess_ready;
    logic [GUESS_W-1:0] guess;
    logic [LEN_W-1:0]   guess_len;

    modport master (
        output guess_valid,
        output guess,
        output guess_len,
        input  guess_ready
    );

    modport slave (
        input  guess_valid,
        input  guess,
        input  guess_len,
        output guess_ready
    );

endinterface

// File: rtl/pwgen_digit.sv
// One odometer character: steps by step_i on carry_i and wraps to restart_i
// past CHAR_MAX; an inactive digit hit by a carry becomes the new top character.
module pwgen_digit
    import md5_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       init_i,
    input  logic [7:0] init_val_i,
    input  logic [7:0] step_i,
    input  logic [7:0] restart_i,
    input  logic       carry_i,
    input  logic       active_i,
    output logic [7:0] char_o,
    output logic       carry_o
);

    logic [7:0] char_q, char_d;
    logic [8:0] sum;
    logic       wrap;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        char_d  = char_q;
        carry_o = 1'b0;
        sum     = {1'b0, char_q} + {1'b0, step_i};
        wrap    = sum > {1'b0, CHAR_MAX};
        if (init_i) begin
            char_d = init_val_i;
        end else if (carry_i) begin
            if (!active_i) begin
                char_d = restart_i;
            end else if (wrap) begin
                char_d  = restart_i;
                carry_o = 1'b1;
            end else begin
                char_d = sum[7:0];
            end
        end
    end

    // NOTE: state is updated with non-blocking assignments only; blocking ones here
    // would make neighbouring registers race on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            char_q <= 8'h00;
        end else begin
            char_q <= char_d;
        end
    end

    assign char_o = char_q;

endmodule

// File: rtl/password_generator.sv
// Brute-force candidate generator: enumerates lowercase guesses of length 1..MAX_LEN
// with a strided first character. Define PWGEN_COUNT_EN to enable guess_count.
module password_generator
    import md5_pkg::*;
#(
    parameter int MAX_LEN = DEFAULT_MAX_LEN
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 stop,
    input  logic [2:0]           increment,
    input  logic [7:0]           starting_position,
    password_generator_if.master guess_if,
    output logic                 busy,
    output logic                 exhausted,
    output logic [COUNT_W-1:0]   guess_count
);

    pwgen_state_t     state_q, state_d;
    logic [2:0]       inc_q, inc_d;
    logic [7:0]       pos_q, pos_d;
    logic [LEN_W-1:0] len_q, len_d;

    logic             start_ok;
    logic             init_digits;
    logic             transfer;
    logic             advance;
    logic             grow;
    logic [MAX_LEN:0] carry;
    logic [7:0]       chars [MAX_LEN];
    logic [GUESS_W-1:0] guess;

    assign start_ok    = start && (state_q != RUN);
    assign init_digits = start_ok && is_guess_char(starting_position);
    assign transfer    = guess_if.guess_valid && guess_if.guess_ready;
    assign advance     = transfer && !stop;
    assign carry[0]    = advance;

    // Char 0 carries the stride and restarts at the start position; the rest count a..z.
    for (genvar i = 0; i < MAX_LEN; i++) begin : g_digit
        pwgen_digit u_digit (
            .clk        (clk),
            .reset      (reset),
            .init_i     (init_digits),
            .init_val_i ((i == 0) ? starting_position : 8'h00),
            .step_i     ((i == 0) ? {5'b0, inc_q} : 8'd1),
            .restart_i  ((i == 0) ? pos_q : CHAR_MIN),
            .carry_i    (carry[i]),
            .active_i   (len_q > LEN_W'(i)),
            .char_o     (chars[i]),
            .carry_o    (carry[i+1])
        );
    end

    // The length grows on the carry leaving the current top character.
    always_comb begin
        grow = 1'b0;
        for (int i = 1; i <= MAX_LEN; i++) begin
            if (len_q == LEN_W'(i)) begin
                grow = carry[i];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        inc_d   = inc_q;
        pos_d   = pos_q;
        len_d   = len_q;
        unique case (state_q)
            IDLE, HALTED, DONE: begin
                if (start) begin
                    inc_d = (increment == 3'd0) ? 3'd1 : increment;
                    pos_d = starting_position;
                    if (is_guess_char(starting_position)) begin
                        len_d   = LEN_W'(1);
                        state_d = RUN;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            RUN: begin
                if (stop) begin
                    state_d = HALTED;
                end else if (advance && grow) begin
                    if (len_q == LEN_W'(MAX_LEN)) begin
                        state_d = DONE;
                    end else begin
                        len_d = len_q + LEN_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            inc_q   <= 3'd0;
            pos_q   <= 8'h00;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            inc_q   <= inc_d;
            pos_q   <= pos_d;
            len_q   <= len_d;
        end
    end

    always_comb begin
        guess = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            guess[GUESS_W-1-8*i -: 8] = chars[i];
        end
    end

    assign guess_if.guess_valid = (state_q == RUN);
    assign guess_if.guess       = guess;
    assign guess_if.guess_len   = len_q;
    assign busy                 = (state_q == RUN);
    assign exhausted            = (state_q == DONE);

`ifdef PWGEN_COUNT_EN
    logic [COUNT_W-1:0] count_q, count_d;

    // A transfer in the same cycle as stop is still counted.
    always_comb begin
        count_d = count_q;
        if (start_ok) begin
            count_d = '0;
        end else if (transfer && (count_q != {COUNT_W{1'b1}})) begin
            count_d = count_q + COUNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign guess_count = count_q;
`else
    assign guess_count = '0;
`endif

endmodule

// File: tb/tb_password_generator.sv
// Directed bench for password_generator (MAX_LEN=2): full sweep, stride,
// backpressure, stop, invalid start and reset. Honours PWGEN_COUNT_EN.
module tb_password_generator;
    import md5_pkg::*;

    localparam int TB_MAX_LEN = 2;
`ifdef PWGEN_COUNT_EN
    localparam bit COUNT_ON = 1'b1;
`else
    localparam bit COUNT_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [2:0]  increment = 3'd1;
    logic [7:0]  starting_position = 8'h61;
    logic        busy;
    logic        exhausted;
    logic [31:0] guess_count;

    int total = 0;
    int bad = 0;

    password_generator_if gif ();

    password_generator #(.MAX_LEN(TB_MAX_LEN)) dut (
        .clk               (clk),
        .reset             (reset),
        .start             (start),
        .stop              (stop),
        .increment         (increment),
        .starting_position (starting_position),
        .guess_if          (gif),
        .busy              (busy),
        .exhausted         (exhausted),
        .guess_count       (guess_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [127:0] g1(input logic [7:0] c0);
        return {c0, 120'h0};
    endfunction

    function automatic logic [127:0] g2(input logic [7:0] c0, input logic [7:0] c1);
        return {c0, c1, 112'h0};
    endfunction

    // Expected guess number idx of an "a", stride-1 run with two characters.
    function automatic logic [127:0] seq_guess(input int idx);
        int j;
        if (idx < 26) return g1(8'(8'h61 + idx));
        j = idx - 26;
        return g2(8'(8'h61 + (j % 26)), 8'(8'h61 + (j / 26)));
    endfunction

    function automatic logic [127:0] seq_len(input int idx);
        return (idx < 26) ? 128'd1 : 128'd2;
    endfunction

    function automatic logic [127:0] exp_count(input int n);
        return COUNT_ON ? 128'(n) : 128'd0;
    endfunction

    logic [7:0] stride_tbl [9] = '{8'h62, 8'h65, 8'h68, 8'h6b, 8'h6e, 8'h71, 8'h74, 8'h77, 8'h7a};

    initial begin
        int idx;
        gif.guess_ready = 1'b1;

        // Reset state
        tick();
        tick();
        check("rst_valid", gif.guess_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_exh", exhausted, 1'b0);
        check("rst_guess", gif.guess, '0);
        check("rst_len", gif.guess_len, 5'd0);
        check("rst_count", guess_count, '0);
        reset = 1'b0;
        tick();
        check("idle_valid", gif.guess_valid, 1'b0);

        // Full two-character sweep from "a", stride 1
        starting_position = 8'h61;
        increment = 3'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 702; k++) begin
            check("sweep_valid", gif.guess_valid, 1'b1);
            check("sweep_guess", gif.guess, seq_guess(k));
            check("sweep_len", gif.guess_len, seq_len(k));
            tick();
        end
        check("sweep_exh", exhausted, 1'b1);
        check("sweep_valid_end", gif.guess_valid, 1'b0);
        check("sweep_busy_end", busy, 1'b0);
        check("sweep_count", guess_count, exp_count(702));
        tick();
        check("sweep_exh_hold", exhausted, 1'b1);

        // Stride 3 from "b": b e h k n q t w z, then "ba"
        starting_position = 8'h62;
        increment = 3'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("stride_exh_clr", exhausted, 1'b0);
        for (int k = 0; k < 9; k++) begin
            check("stride_guess", gif.guess, g1(stride_tbl[k]));
            check("stride_len", gif.guess_len, 5'd1);
            tick();
        end
        check("stride_wrap", gif.guess, g2(8'h62, 8'h61));
        check("stride_wrap_len", gif.guess_len, 5'd2);
        tick();
        check("stride_ea", gif.guess, g2(8'h65, 8'h61));

        // start while running is ignored
        starting_position = 8'h6d;
        increment = 3'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_in_run", gif.guess, g2(8'h68, 8'h61));
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("stride_halt_valid", gif.guess_valid, 1'b0);
        check("stride_halt_count", guess_count, exp_count(12));

        // Increment 0 acts as 1; backpressure; stop on "ca"
        starting_position = 8'h61;
        increment = 3'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("inc0_first", gif.guess, seq_guess(0));
        check("inc0_count_clr", guess_count, exp_count(0));
        tick();
        idx = 1;
        check("inc0_second", gif.guess, seq_guess(1));
        while (idx < 5) begin
            tick();
            idx++;
        end
        gif.guess_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("bp_guess", gif.guess, seq_guess(5));
            check("bp_len", gif.guess_len, 5'd1);
            check("bp_valid", gif.guess_valid, 1'b1);
        end
        check("bp_count", guess_count, exp_count(5));
        gif.guess_ready = 1'b1;
        tick();
        idx = 6;
        check("bp_resume", gif.guess, seq_guess(6));
        while (idx < 28) begin
            tick();
            idx++;
        end
        check("at_ca", gif.guess, g2(8'h63, 8'h61));
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("stop_valid", gif.guess_valid, 1'b0);
        check("stop_busy", busy, 1'b0);
        check("stop_exh", exhausted, 1'b0);
        check("stop_count", guess_count, exp_count(29));
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("stop_idle_busy", busy, 1'b0);
        check("stop_idle_count", guess_count, exp_count(29));

        // Restart from HALTED begins again at length 1
        starting_position = 8'h78;
        increment = 3'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("restart_guess", gif.guess, g1(8'h78));
        check("restart_len", gif.guess_len, 5'd1);
        check("restart_valid", gif.guess_valid, 1'b1);
        stop = 1'b1;
        tick();
        stop = 1'b0;

        // Out-of-range start goes straight to exhausted
        starting_position = 8'h7b;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("bad_pos_exh", exhausted, 1'b1);
        check("bad_pos_valid", gif.guess_valid, 1'b0);
        tick();
        check("bad_pos_valid2", gif.guess_valid, 1'b0);
        check("bad_pos_busy", busy, 1'b0);

        // Reset mid-run, with start and stop asserted during reset
        starting_position = 8'h61;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("pre_rst_guess", gif.guess, seq_guess(1));
        reset = 1'b1;
        start = 1'b1;
        stop = 1'b1;
        tick();
        check("mid_rst_valid", gif.guess_valid, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_exh", exhausted, 1'b0);
        check("mid_rst_guess", gif.guess, '0);
        check("mid_rst_len", gif.guess_len, 5'd0);
        check("mid_rst_count", guess_count, '0);
        tick();
        reset = 1'b0;
        start = 1'b0;
        stop = 1'b0;
        tick();
        check("post_rst_valid", gif.guess_valid, 1'b0);
        check("post_rst_busy", busy, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/password_generator.md
# password_generator

Upstream candidate-generation stage of the brute-force MD5 cracker. It enumerates lowercase plaintext guesses of length 1..MAX_LEN and streams them, one per cycle, over a valid/ready handshake into the MD5 hashing/compare stage. The first character is strided by `increment` from `starting_position`, so several cracker cores partition the key space by first character. Enumeration halts on a match signal from downstream or on exhaustion of the space.

## Interface
- MAX_LEN, 5, maximum guess length in characters (1..16)
- CHAR_MIN, 8'h61 ("a"), lowest character value
- CHAR_MAX, 8'h7a ("z"), highest character value
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high; one clock, reset is synchronous and active-high
- start  in  1  pulse; begins enumeration; sampled only in IDLE, HALTED, DONE
- stop  in  1  match found downstream (hashes_equal); halts enumeration
- increment  in  3  stride of character 0; value 0 treated as 1; sampled on start
- starting_position  in  8  first value of character 0; sampled on start
- guess_ready  in  1  downstream accepts guess this cycle
- guess_valid  out  1  guess/guess_len hold a valid candidate
- guess  out  128  candidate, char i at guess[127-8i -: 8], unused bytes 0
- guess_len  out  5  number of valid characters (1..MAX_LEN)
- busy  out  1  state is RUN
- exhausted  out  1  whole space emitted without stop; held until start/reset
- guess_count  out  32  accepted guesses since last start (see Configuration)

## Operation
- FSM states: IDLE, RUN, HALTED, DONE.
- IDLE/HALTED/DONE + start: latch increment (0→1) and starting_position; if starting_position outside [CHAR_MIN,CHAR_MAX] → DONE with exhausted=1, no guess emitted; else → RUN, len=1, char0=starting_position, chars 1..15 = 0.
- RUN: guess_valid=1. Advance only on guess_valid && guess_ready (transfer).
- Advance (odometer, char 0 least significant): char0_next = char0 + increment in 9-bit arithmetic; if > CHAR_MAX, char0 ← starting_position and carry into char 1. Chars 1..len-1: +1, CHAR_MAX wraps to CHAR_MIN with carry.
- Carry out of char len-1: len ← len+1, char0 ← starting_position, chars 1..len ← CHAR_MIN. If len == MAX_LEN: → DONE, exhausted=1, guess_valid=0.
- stop in RUN → HALTED; stop has priority over advance, but a transfer in that same cycle still counts. stop outside RUN is ignored.
- start while in RUN is ignored.
- Reset values: state IDLE; guess_valid, busy, exhausted 0; guess 0; guess_len 0; guess_count 0.

## Timing
- start → guess_valid=1 with first guess on the next cycle (1-cycle latency).
- With guess_ready held high, one new guess per cycle. No bubbles across length increments.
- guess_valid && !guess_ready: guess and guess_len held stable; guess_valid stays high (AXI-style; valid never retracts except on stop, reset or exhaustion).
- stop at cycle N → guess_valid=0, busy=0 at N+1.
- The last transfer at cycle N → DONE and exhausted=1 at N+1.
- reset mid-RUN → all outputs at reset values on the next cycle; no partial guess emitted.

## Configuration
- PWGEN_COUNT_EN defined: 32-bit guess_count increments on each transfer, cleared on start and reset, frozen in HALTED/DONE, saturates at 32'hFFFF_FFFF.
- PWGEN_COUNT_EN undefined: counter logic absent; guess_count tied to 0.

## Structure
- Shared package md5_pkg: CHAR_MIN, CHAR_MAX, default MAX_LEN, pwgen_state_t enum (IDLE, RUN, HALTED, DONE).
- Sub-module pwgen_digit: one odometer character with inputs step, restart value and carry_in; outputs char and carry_out. Instantiate MAX_LEN times; char 0 uses the strided step and starting_position, the others use step 1 and CHAR_MIN.

## Test plan
- MAX_LEN=2, start="a", inc=1, ready=1 → "a".."z", "aa", "ba", .., "za", "ab", .., "zz"; 702 transfers, then exhausted=1; guess_count=702.
- start="b", inc=3, MAX_LEN=1 → b,e,h,k,n,q,t,w,z (9 guesses), then exhausted; inc=0 behaves as inc=1.
- Backpressure: ready low 3 cycles mid-stream → guess, guess_len and valid stable; no skipped or duplicated guesses after ready returns.
- stop with a coincident transfer on guess "ca" → that transfer counted, valid=0 next cycle, state HALTED; new start restarts at len 1.
- starting_position=8'h7b ("{") → exhausted=1 next cycle, guess_valid never asserts.
- reset asserted mid-RUN → next cycle all outputs 0, state IDLE; start and stop ignored during reset.
